// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a START/DATA/STOP serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx #(
  parameter int CLKS_PER_BIT = 280,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;
  logic [7:0]  head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ready_o = !full;
  assign push    = valid_i && ready_o && !rst_i;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define valid entries.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

  // --------------------------------------------------------- serialiser
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d, bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)    par_q <= 1'b0;
    else if (pop) par_q <= ^head;
  end
`endif

  assign bit_end = (cnt_q == CNT_MAX);
  assign busy_o  = (state_q != IDLE) || !empty;

  // NOTE: every signal gets a default before the case so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          // Back-to-back frames: reload straight into START with no idle bit.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the current state, so it lags the state register by one edge.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_o    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_o    <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 280, clock cycles per bit; 115200 baud at the 32.256 MHz system clock; legal values are 2 and above.
REQ-002 Parameter FIFO_DEPTH, default 4, number of entries in the byte FIFO; SHALL be a power of two, 2 or more.
REQ-003 clk_i  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 data_i  input  8  byte to transmit.
REQ-006 valid_i  input  1  data_i is valid this cycle.
REQ-007 ready_o  output  1  FIFO can accept a byte; high exactly when the FIFO is not full.
REQ-008 tx_o  output  1  serial line, idle high; SHALL be driven directly from a flop.
REQ-009 busy_o  output  1  high when a frame is in progress or the FIFO is non-empty.

Function
REQ-010 A byte SHALL be written to the FIFO on every rising edge where valid_i and ready_o are both high; valid_i while ready_o is low SHALL be ignored.
REQ-011 The FSM SHALL have the states IDLE, START, DATA, PARITY (only with the macro) and STOP.
REQ-012 Each non-IDLE state SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter of width $clog2(CLKS_PER_BIT) that counts 0 to CLKS_PER_BIT-1.
REQ-013 IDLE with the FIFO non-empty: pop the head byte into the shift register, go to START, and drive tx_o=0 from the next edge.
REQ-014 DATA SHALL send 8 bits LSB first, using a 3-bit bit index, then go to STOP (or PARITY).
REQ-015 STOP SHALL drive tx_o=1 for one bit time.
REQ-016 At the end of STOP, if the FIFO is non-empty, the FSM SHALL go straight to START with no idle gap; otherwise it SHALL go to IDLE.
REQ-017 Latency: for a byte accepted at edge N while the FSM is IDLE and the FIFO is empty, tx_o SHALL fall at edge N+2 (write at N, pop at N+1, registered output at N+2).
REQ-018 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-019 When the FIFO is full, ready_o SHALL go high on the cycle after a pop.
REQ-020 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be decided using an extra pointer MSB.
REQ-021 busy_o SHALL fall on the same edge the FSM enters IDLE with the FIFO empty.

Reset
REQ-022 While rst_i is high, on every edge: tx_o=1, state=IDLE, counters=0, FIFO empty, ready_o=1, busy_o=0.
REQ-023 Reset mid-frame SHALL abandon the frame, return tx_o to 1 at the reset edge, and discard all queued bytes.
REQ-024 A byte presented with valid_i in a cycle where rst_i is high SHALL NOT be stored.

Configuration
REQ-025 Macro UART_TX_PARITY_EN: when defined, a PARITY state SHALL sit between DATA and STOP and send even parity (XOR of the 8 data bits) for one bit time, giving an 11-bit frame.
REQ-026 When UART_TX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent, giving a 10-bit frame.

Verification
REQ-027 Reset, then push 0x55 once with default parameters -> tx_o falls 2 cycles after acceptance; sampling at mid-bit (cycle 140 of each bit) gives 0,1,0,1,0,1,0,1,0,1; tx_o then idles high and busy_o drops after 2800 cycles of frame.
REQ-028 Push 0xA5, 0x00, 0xFF, 0x3C, 0x81 back-to-back holding valid_i -> 4 bytes are accepted before ready_o drops; the 5th is accepted once the first is popped; all 5 frames appear contiguous and in order, with no idle cycles between stop and start bits.
REQ-029 Hold valid_i high with FIFO full -> no overwrite; FIFO contents and frame order are unchanged.
REQ-030 Assert rst_i for one cycle during bit 3 of a 0x0F frame with 2 bytes queued -> tx_o=1 after the reset edge, ready_o=1, busy_o=0, and no further frames appear.
REQ-031 With UART_TX_PARITY_EN defined, send 0x07 and then 0x03 -> parity bits are 1 and 0 respectively, and each frame lasts 3080 cycles.
REQ-032 Set CLKS_PER_BIT=2 and push 0xC3 -> each bit lasts exactly 2 cycles; the frame lasts 20 cycles.
